// File: rtl/alu_op_sequencer_if.sv
// Shared opcode/ALU-function types and the decoder-to-sequencer-to-datapath bus.
// The slave modport is the sequencer; the master modport is the surrounding environment.
package opcodes;
  typedef enum logic [4:0] {
    ADD = 5'd0, ADDI, ADDIB, LDW, STW, BRANCH, INTERRUPT,
    ADC, ADCI, SUC, SUCI,
    SUB, SUBI, SUBIB, CMP, CMPI,
    NEG, AND, OR, XOR, NAND, NOT, NOR,
    LUI, LLI,
    LSL, LSR, ASR,
    PUSH, POP
  } Opcode_t;

  typedef enum logic [3:0] {
    FnADD = 4'd0, FnADC, FnSUB, FnNEG, FnAND, FnOR, FnXOR, FnNAND,
    FnNOR, FnNOT, FnLUI, FnLLI, FnLSL, FnLSR, FnASR
  } alu_functions_t;
endpackage

interface alu_op_sequencer_if #(
  parameter int unsigned SHAMT_W = 4
);
  logic                    InValid;
  logic                    InReady;
  opcodes::Opcode_t        OpCode;
  logic [SHAMT_W-1:0]      ShAmt;
  logic                    OutValid;
  logic                    OutReady;
  opcodes::alu_functions_t AluOp;
  logic                    ShiftEn;
  logic                    StepFirst;
  logic                    StepLast;
  logic                    FlagWe;
  logic                    WbEn;
  logic                    Illegal;

  modport slave (
    input  InValid, OpCode, ShAmt, OutReady,
    output InReady, OutValid, AluOp, ShiftEn, StepFirst, StepLast, FlagWe, WbEn, Illegal
  );

  modport master (
    output InValid, OpCode, ShAmt, OutReady,
    input  InReady, OutValid, AluOp, ShiftEn, StepFirst, StepLast, FlagWe, WbEn, Illegal
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Accepts one instruction per handshake and issues a registered stream of ALU micro-steps.
// Shifts expand to ShAmt 1-bit steps, PUSH/POP to two-step stack sequences.
module alu_op_sequencer #(
  parameter int unsigned SHAMT_W = 4
) (
  input logic              Clock,
  input logic              nReset,
  alu_op_sequencer_if.slave bus
);
  import opcodes::*;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StIssue = 1'b1;

  typedef struct packed {
    alu_functions_t fn;
    logic           shift;
    logic           last;
    logic           flag;
    logic           wb;
    logic           ill;
  } step_t;

  // cnt is the number of steps remaining including the one being decoded.
  function automatic step_t decode(Opcode_t op, logic [SHAMT_W-1:0] cnt, logic shift_nz);
    step_t s;
    s      = '0;
    s.fn   = FnADD;
    s.last = (cnt == SHAMT_W'(1));
    case (op)
      ADD, ADDI, ADDIB:        begin s.flag = 1'b1; s.wb = 1'b1; end
      LDW, INTERRUPT:          s.wb = 1'b1;
      STW, BRANCH:             s.wb = 1'b0;
      ADC, ADCI, SUC, SUCI:    begin s.fn = FnADC; s.flag = 1'b1; s.wb = 1'b1; end
      SUB, SUBI, SUBIB:        begin s.fn = FnSUB; s.flag = 1'b1; s.wb = 1'b1; end
      CMP, CMPI:               begin s.fn = FnSUB; s.flag = 1'b1; end
      NEG:                     begin s.fn = FnNEG;  s.flag = 1'b1; s.wb = 1'b1; end
      AND:                     begin s.fn = FnAND;  s.flag = 1'b1; s.wb = 1'b1; end
      OR:                      begin s.fn = FnOR;   s.flag = 1'b1; s.wb = 1'b1; end
      XOR:                     begin s.fn = FnXOR;  s.flag = 1'b1; s.wb = 1'b1; end
      NAND:                    begin s.fn = FnNAND; s.flag = 1'b1; s.wb = 1'b1; end
      // Datapath operand convention swaps NOT and NOR.
      NOT:                     begin s.fn = FnNOR;  s.flag = 1'b1; s.wb = 1'b1; end
      NOR:                     begin s.fn = FnNOT;  s.flag = 1'b1; s.wb = 1'b1; end
      LUI:                     begin s.fn = FnLUI; s.wb = 1'b1; end
      LLI:                     begin s.fn = FnLLI; s.wb = 1'b1; end
      LSL, LSR, ASR: begin
        s.fn    = (op == LSL) ? FnLSL : ((op == LSR) ? FnLSR : FnASR);
        s.shift = shift_nz;
        s.wb    = 1'b1;
        s.flag  = s.last;
      end
      PUSH: begin
        s.fn = s.last ? FnADD : FnSUB;
        s.wb = !s.last;
      end
      POP:                     s.wb = s.last;
      default:                 s.ill = 1'b1;
    endcase
    return s;
  endfunction

  logic [0:0]         state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  Opcode_t            op_q, op_d;
  step_t              step_q, step_d;
  logic               first_q, first_d;
  logic               valid_q, valid_d;

  logic               advance;
  logic               in_ready;
  logic               accept;
  logic [SHAMT_W-1:0] n_steps;
  logic [SHAMT_W-1:0] cnt_dec;

  always_comb begin
    advance  = valid_q && bus.OutReady;
    in_ready = (state_q == StIdle) || (advance && step_q.last);
    accept   = bus.InValid && in_ready;
    cnt_dec  = cnt_q - SHAMT_W'(1);

    case (bus.OpCode)
      LSL, LSR, ASR: n_steps = (bus.ShAmt == '0) ? SHAMT_W'(1) : bus.ShAmt;
      PUSH, POP:     n_steps = SHAMT_W'(2);
      default:       n_steps = SHAMT_W'(1);
    endcase

    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    step_d  = step_q;
    first_d = first_q;
    valid_d = valid_q;

    if (accept) begin
      state_d = StIssue;
      cnt_d   = n_steps;
      op_d    = bus.OpCode;
      step_d  = decode(bus.OpCode, n_steps, bus.ShAmt != '0);
      first_d = 1'b1;
      valid_d = 1'b1;
    end else if (advance) begin
      if (step_q.last) begin
        state_d   = StIdle;
        valid_d   = 1'b0;
        first_d   = 1'b0;
        step_d    = '0;
        step_d.fn = FnADD;
      end else begin
        cnt_d   = cnt_dec;
        // ShiftEn is constant across a shift sequence, so the registered copy is reused.
        step_d  = decode(op_q, cnt_dec, step_q.shift);
        first_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= ADD;
      step_q  <= '0;
      first_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      step_q  <= step_d;
      first_q <= first_d;
      valid_q <= valid_d;
    end
  end

  assign bus.InReady   = in_ready;
  assign bus.OutValid  = valid_q;
  assign bus.AluOp     = step_q.fn;
  assign bus.ShiftEn   = step_q.shift;
  assign bus.StepFirst = first_q;
  assign bus.StepLast  = step_q.last;
  assign bus.FlagWe    = step_q.flag;
  assign bus.WbEn      = step_q.wb;
  assign bus.Illegal   = step_q.ill;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: vector table, directed multi-cycle corners and random traffic
// checked against a queue of expected micro-steps expanded from each accepted instruction.
module tb_alu_op_sequencer;
  import opcodes::*;

  localparam int unsigned W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.SHAMT_W(W)) bus ();
  alu_op_sequencer #(.SHAMT_W(W)) dut (
    .Clock  (clk),
    .nReset (rst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [3:0] fn;
    logic       sh;
    logic       first;
    logic       last;
    logic       flag;
    logic       wb;
    logic       ill;
  } step_t;

  typedef struct {
    Opcode_t        op;
    alu_functions_t fn;
    logic           flag;
    logic           wb;
    logic           ill;
  } vec_t;

  step_t q[$];
  step_t act;
  step_t saved;
  logic  act_valid;
  logic  act_ready;
  int    total = 0;
  int    bad   = 0;
  vec_t  vt[20];

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  function automatic step_t mk(alu_functions_t fn, logic sh, logic first, logic last,
                               logic flag, logic wb, logic ill);
    step_t s;
    s.fn = fn; s.sh = sh; s.first = first; s.last = last;
    s.flag = flag; s.wb = wb; s.ill = ill;
    return s;
  endfunction

  // Expand one instruction into its full list of expected micro-steps.
  task automatic model_push(input Opcode_t op, input logic [W-1:0] sh);
    int             n;
    alu_functions_t fn;
    logic           flag, wb, ill;
    if (op inside {LSL, LSR, ASR}) begin
      n  = (sh == 0) ? 1 : int'(sh);
      fn = (op == LSL) ? FnLSL : (op == LSR) ? FnLSR : FnASR;
      for (int i = 0; i < n; i++)
        q.push_back(mk(fn, sh != 0, i == 0, i == n - 1, i == n - 1, 1'b1, 1'b0));
    end else if (op == PUSH) begin
      q.push_back(mk(FnSUB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
      q.push_back(mk(FnADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    end else if (op == POP) begin
      q.push_back(mk(FnADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      q.push_back(mk(FnADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    end else begin
      case (op)
        ADC, ADCI, SUC, SUCI:     fn = FnADC;
        SUB, SUBI, SUBIB, CMP, CMPI: fn = FnSUB;
        NEG:  fn = FnNEG;
        AND:  fn = FnAND;
        OR:   fn = FnOR;
        XOR:  fn = FnXOR;
        NAND: fn = FnNAND;
        NOT:  fn = FnNOR;
        NOR:  fn = FnNOT;
        LUI:  fn = FnLUI;
        LLI:  fn = FnLLI;
        default: fn = FnADD;
      endcase
      ill  = !(op inside {ADD, ADDI, ADDIB, LDW, STW, BRANCH, INTERRUPT, ADC, ADCI, SUC, SUCI,
                          SUB, SUBI, SUBIB, CMP, CMPI, NEG, AND, OR, XOR, NAND, NOT, NOR,
                          LUI, LLI});
      flag = !ill && (op inside {ADD, ADDI, ADDIB, ADC, ADCI, SUC, SUCI, SUB, SUBI, SUBIB,
                                 CMP, CMPI, NEG, AND, OR, XOR, NAND, NOT, NOR});
      wb   = !ill && !(op inside {CMP, CMPI, STW, BRANCH});
      q.push_back(mk(fn, 1'b0, 1'b1, 1'b1, flag, wb, ill));
    end
  endtask

  // One clock: drive inputs after the falling edge, sample, score against the model.
  task automatic cyc(input logic v, input Opcode_t op, input logic [W-1:0] sh, input logic rdy);
    logic exp_ready;
    @(negedge clk);
    bus.InValid  = v;
    bus.OpCode   = op;
    bus.ShAmt    = sh;
    bus.OutReady = rdy;
    #1;
    act       = {bus.AluOp, bus.ShiftEn, bus.StepFirst, bus.StepLast, bus.FlagWe, bus.WbEn,
                 bus.Illegal};
    act_valid = bus.OutValid;
    act_ready = bus.InReady;
    exp_ready = (q.size() == 0) || (rdy && q[0].last);
    check("out_valid", act_valid, q.size() != 0);
    check("in_ready", act_ready, exp_ready);
    if (q.size() != 0) begin
      check("step", act, q[0]);
      if (rdy) void'(q.pop_front());
    end
    if (v && exp_ready) model_push(op, sh);
  endtask

  initial begin
    logic [4:0] rop;
    int         steps;

    vt[0]  = '{ADD,       FnADD,  1'b1, 1'b1, 1'b0};
    vt[1]  = '{LDW,       FnADD,  1'b0, 1'b1, 1'b0};
    vt[2]  = '{STW,       FnADD,  1'b0, 1'b0, 1'b0};
    vt[3]  = '{BRANCH,    FnADD,  1'b0, 1'b0, 1'b0};
    vt[4]  = '{INTERRUPT, FnADD,  1'b0, 1'b1, 1'b0};
    vt[5]  = '{ADCI,      FnADC,  1'b1, 1'b1, 1'b0};
    vt[6]  = '{SUCI,      FnADC,  1'b1, 1'b1, 1'b0};
    vt[7]  = '{SUBIB,     FnSUB,  1'b1, 1'b1, 1'b0};
    vt[8]  = '{CMP,       FnSUB,  1'b1, 1'b0, 1'b0};
    vt[9]  = '{CMPI,      FnSUB,  1'b1, 1'b0, 1'b0};
    vt[10] = '{NEG,       FnNEG,  1'b1, 1'b1, 1'b0};
    vt[11] = '{AND,       FnAND,  1'b1, 1'b1, 1'b0};
    vt[12] = '{XOR,       FnXOR,  1'b1, 1'b1, 1'b0};
    vt[13] = '{NAND,      FnNAND, 1'b1, 1'b1, 1'b0};
    vt[14] = '{NOT,       FnNOR,  1'b1, 1'b1, 1'b0};
    vt[15] = '{NOR,       FnNOT,  1'b1, 1'b1, 1'b0};
    vt[16] = '{LUI,       FnLUI,  1'b0, 1'b1, 1'b0};
    vt[17] = '{LLI,       FnLLI,  1'b0, 1'b1, 1'b0};
    vt[18] = '{Opcode_t'(5'd30), FnADD, 1'b0, 1'b0, 1'b1};
    vt[19] = '{Opcode_t'(5'd31), FnADD, 1'b0, 1'b0, 1'b1};

    bus.InValid  = 1'b0;
    bus.OpCode   = ADD;
    bus.ShAmt    = '0;
    bus.OutReady = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, ADD, 4'd0, 1'b1);
    check("rst_outputs", act, 10'h0);

    foreach (vt[i]) begin
      cyc(1'b1, vt[i].op, 4'(i), 1'b1);
      cyc(1'b0, ADD, 4'd0, 1'b1);
      check($sformatf("vec%0d_fn", i), act.fn, vt[i].fn);
      check($sformatf("vec%0d_ctl", i), {act.first, act.last, act.flag, act.wb, act.ill},
            {1'b1, 1'b1, vt[i].flag, vt[i].wb, vt[i].ill});
    end

    // LSL 3 then ASR 0, back to back.
    cyc(1'b1, LSL, 4'd3, 1'b1);
    cyc(1'b1, ASR, 4'd0, 1'b1);
    check("lsl_s1", {act.fn, act.sh, act.first, act.last}, {FnLSL, 1'b1, 1'b1, 1'b0});
    cyc(1'b1, ASR, 4'd0, 1'b1);
    check("lsl_s2_notlast", act.last, 1'b0);
    cyc(1'b1, ASR, 4'd0, 1'b1);
    check("lsl_s3_last_ready", {act.last, act_ready}, 2'b11);
    cyc(1'b0, ADD, 4'd0, 1'b1);
    check("asr0_step", {act_valid, act.fn, act.sh, act.first, act.last},
          {1'b1, FnASR, 1'b0, 1'b1, 1'b1});

    // PUSH with OutReady 1,0,0,1.
    cyc(1'b1, PUSH, 4'd0, 1'b1);
    cyc(1'b0, ADD, 4'd0, 1'b1);
    check("push_s1", {act.fn, act.wb, act_ready}, {FnSUB, 1'b1, 1'b0});
    cyc(1'b0, ADD, 4'd0, 1'b0);
    check("push_s2", {act.fn, act.wb, act.last, act_ready}, {FnADD, 1'b0, 1'b1, 1'b0});
    saved = act;
    cyc(1'b1, SUB, 4'd7, 1'b0);
    check("push_stall_hold", act, saved);
    cyc(1'b0, ADD, 4'd0, 1'b1);
    check("push_release_ready", act_ready, 1'b1);
    cyc(1'b0, ADD, 4'd0, 1'b1);

    // Maximum shift amount runs the full 15 steps.
    cyc(1'b1, LSR, 4'd15, 1'b1);
    steps = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, ADD, 4'd0, 1'b1);
      if (act_valid) steps++;
    end
    check("max_shift_steps", steps, 15);

    // Reset in the middle of a long shift.
    cyc(1'b1, LSL, 4'd15, 1'b1);
    repeat (4) cyc(1'b0, ADD, 4'd0, 1'b1);
    cyc(1'b0, ADD, 4'd0, 1'b0);
    check("mid_step5_valid", act_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_clear", {bus.OutValid, bus.AluOp, bus.ShiftEn, bus.StepFirst,
          bus.StepLast, bus.FlagWe, bus.WbEn, bus.Illegal}, 11'h0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) cyc(1'b0, ADD, 4'd0, 1'b1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 3000; i++) begin
      rop = 5'($urandom_range(0, 31));
      cyc($urandom_range(0, 3) != 0, Opcode_t'(rop), 4'($urandom_range(0, 15)),
          $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 40; i++) cyc(1'b0, ADD, 4'd0, 1'b1);
    check("drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle successor to the combinational ALU-function decode. It accepts one instruction (OpCode plus shift amount) per handshake and issues a registered stream of per-cycle ALU micro-steps to the datapath, each carrying opcodes::alu_functions_t AluOp and its control strobes. Shifts run as ShAmt single-bit steps. PUSH and POP run as two-step stack sequences. The block sits between the instruction decoder and the ALU/register-file control. It applies backpressure upstream and honours datapath stalls.

## Interface
- SHAMT_W, default 4: width of shift amount and step counter; max shift is 2^SHAMT_W-1.
- Clock  in  1  rising-edge clock.
- nReset  in  1  asynchronous active-low reset.
- InValid  in  1  OpCode/ShAmt valid.
- InReady  out  1  block can accept an instruction this cycle.
- OpCode  in  opcodes::Opcode_t  instruction opcode.
- ShAmt  in  SHAMT_W  shift amount; used only for LSL/LSR/ASR.
- OutValid  out  1  current micro-step valid.
- OutReady  in  1  datapath consumes the micro-step this cycle.
- AluOp  out  opcodes::alu_functions_t  ALU function for this step.
- ShiftEn  out  1  ALU performs a 1-bit shift this step; 0 means pass-through.
- StepFirst  out  1  first step of the instruction.
- StepLast  out  1  final step of the instruction.
- FlagWe  out  1  write status flags. Valid only with StepLast.
- WbEn  out  1  write the result register this step.
- Illegal  out  1  opcode not in the map. Asserted with the single issued step.

## Operation
- States: IDLE, ISSUE.
- Accept occurs when InValid && InReady. On accept, the block latches OpCode, loads the step counter, and enters ISSUE. Outputs are registered, so the first step appears on the cycle after accept.
- Step count N:
  - LSL/LSR/ASR: N = max(ShAmt, 1).
  - PUSH/POP: N = 2.
  - All other opcodes: N = 1.
- Single-step map:
  - ADD/ADDI/ADDIB/LDW/STW/BRANCH/INTERRUPT → FnADD.
  - ADC/ADCI/SUC/SUCI → FnADC.
  - SUB/SUBI/SUBIB/CMP/CMPI → FnSUB.
  - NEG → FnNEG, AND → FnAND, OR → FnOR, XOR → FnXOR, NAND → FnNAND.
  - NOT → FnNOR, NOR → FnNOT (datapath operand convention).
  - LUI → FnLUI, LLI → FnLLI.
- Shifts: every step carries the shift function. ShiftEn = 1 on every step when ShAmt ≥ 1. ShiftEn = 0 on the single step when ShAmt = 0.
- PUSH: step 1 FnSUB (SP decrement, WbEn=1); step 2 FnADD (address, WbEn=0).
- POP: step 1 FnADD (address, WbEn=0); step 2 FnADD (SP increment, WbEn=1).
- FlagWe = 1 on StepLast for arithmetic, logic, NEG, CMP/CMPI and shift opcodes. FlagWe = 0 for LDW, STW, LUI, LLI, BRANCH, INTERRUPT, PUSH and POP.
- WbEn = 1 on StepLast for all single-step and shift opcodes except CMP, CMPI, STW and BRANCH. For shifts, WbEn = 1 on every step.
- Unmapped opcode: one step, AluOp = FnADD, FlagWe = 0, WbEn = 0, Illegal = 1.
- The step advances only when OutValid && OutReady. The counter decrements on each advance, and StepLast = 1 when the counter equals 1.

## Timing
- Reset (async assert, sync-to-Clock deassert use):
  - state = IDLE; OutValid = 0; StepFirst = StepLast = 0; FlagWe = WbEn = ShiftEn = Illegal = 0; AluOp = FnADD.
  - InReady = 1 in the first cycle after reset.
- InReady = (state == IDLE) || (OutValid && OutReady && StepLast). Back-to-back instructions therefore incur zero bubbles.
- Latency: accept at cycle t gives the first step at t+1. With no stall, the last step occurs at t+N.
- Stall: while OutValid && !OutReady, all outputs hold stable and the counter holds.
- Accept coincident with final-step consumption: the next instruction's first step appears in the following cycle, and OutValid stays 1.
- Reset mid-sequence abandons the instruction. No partial steps are issued after release.
- ShAmt = 2^SHAMT_W-1 issues exactly 2^SHAMT_W-1 steps with no counter wrap.
- Inputs are sampled only on accept. Changes to them during ISSUE have no effect.

## Test plan
- Reset, then ADD with OutReady = 1: one step at t+1 with AluOp = FnADD, StepFirst = StepLast = 1, FlagWe = 1, WbEn = 1; InReady = 1 throughout.
- LSL with ShAmt = 3, then ASR with ShAmt = 0, back-to-back: three FnLSL steps with ShiftEn = 1, StepLast only on the 3rd step. Next cycle: one FnASR step with ShiftEn = 0. No idle cycle between the two instructions.
- PUSH with OutReady toggling 1,0,0,1: step 1 FnSUB/WbEn = 1 and step 2 FnADD/WbEn = 0. Outputs stay frozen while stalled, and InReady = 0 until step 2 is consumed.
- CMP, NOT, NOR: FnSUB with WbEn = 0 and FlagWe = 1; FnNOR; FnNOT.
- Unmapped opcode value: single FnADD step with Illegal = 1, FlagWe = 0, WbEn = 0.
- LSL with ShAmt = 15 and nReset pulsed low at step 5: all outputs clear asynchronously; after release InReady = 1, OutValid = 0, and no further steps are issued.
